// File: rtl/emu_bus_bridge.sv
// PMOD-pin to core-wrapper front end for the FPGA emulator: input synchronisers,
// output retiming, switch debounce, PLL-lock-qualified core reset and a run heartbeat.
module emu_bus_bridge #(
    parameter int DATA_W      = 8,
    parameter int CTRL_IN_W   = 3,
    parameter int CTRL_OUT_W  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int OUT_STAGES  = 2,
    parameter int SWITCH_W    = 2,
    parameter int DEB_CYCLES  = 2**16,
    parameter int LOCK_CYCLES = 256,
    parameter int HB_W        = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock_i,
    input  logic [SWITCH_W-1:0]   switch_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [CTRL_IN_W-1:0]  data_ctrl_i,
    output logic [DATA_W-1:0]     data_o,
    output logic [CTRL_IN_W-1:0]  data_ctrl_o,
    input  logic [DATA_W-1:0]     hash_i,
    input  logic [CTRL_OUT_W-1:0] hash_ctrl_i,
    output logic [DATA_W-1:0]     hash_o,
    output logic [CTRL_OUT_W-1:0] hash_ctrl_o,
    output logic [SWITCH_W-1:0]   switch_o,
    output logic                  core_rst_n_o,
    output logic                  lock_lost_o,
    output logic                  heartbeat_o
);

    localparam int IN_W   = SWITCH_W + CTRL_IN_W + DATA_W;
    localparam int OUT_W  = CTRL_OUT_W + DATA_W;
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Switches share the data synchroniser so every async pin sees the same depth.
    logic [IN_W-1:0]     in_sync_q [SYNC_STAGES];
    logic [SWITCH_W-1:0] sw_s;

    // NOTE: the sync/retime chains are reset too, so nothing stale leaks out after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) in_sync_q[s] <= '0;
        end else begin
            in_sync_q[0] <= {switch_i, data_ctrl_i, data_i};
            for (int s = 1; s < SYNC_STAGES; s++) in_sync_q[s] <= in_sync_q[s-1];
        end
    end

    assign {sw_s, data_ctrl_o, data_o} = in_sync_q[SYNC_STAGES-1];

    generate
        if (OUT_STAGES == 0) begin : g_out_comb
            assign {hash_ctrl_o, hash_o} = {hash_ctrl_i, hash_i};
        end else begin : g_out_reg
            logic [OUT_W-1:0] out_pipe_q [OUT_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < OUT_STAGES; s++) out_pipe_q[s] <= '0;
                end else begin
                    out_pipe_q[0] <= {hash_ctrl_i, hash_i};
                    for (int s = 1; s < OUT_STAGES; s++) out_pipe_q[s] <= out_pipe_q[s-1];
                end
            end

            assign {hash_ctrl_o, hash_o} = out_pipe_q[OUT_STAGES-1];
        end
    endgenerate

    logic [1:0] lock_sync_q;
    logic       lock_s;

    assign lock_s = lock_sync_q[1];

    // Debounce: a switch flips only after DEB_CYCLES consecutive disagreeing samples.
    logic [SWITCH_W-1:0] sw_q, sw_d;
    logic [DEB_W-1:0]    deb_cnt_q [SWITCH_W];
    logic [DEB_W-1:0]    deb_cnt_d [SWITCH_W];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sw_d = sw_q;
        for (int i = 0; i < SWITCH_W; i++) begin
            deb_cnt_d[i] = '0;
            if (sw_s[i] != sw_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) sw_d[i] = ~sw_q[i];
                else                                        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    logic [1:0]        state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              lost_q, lost_d;
    logic              core_rst_n_q;
    logic [HB_W-1:0]   hb_q, hb_d;

    // Lock loss is tested ahead of the user hold-off so it wins when both occur together.
    always_comb begin
        state_d = state_q;
        lcnt_d  = '0;
        lost_d  = lost_q;
        case (state_q)
            ST_IDLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lock_s && !sw_q[0]) begin
                    if (lcnt_q == LCNT_W'(LOCK_CYCLES - 1)) state_d = ST_RUN;
                    else                                    lcnt_d  = lcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    lost_d  = 1'b1;
                end else if (sw_q[0]) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hb_d = (state_q == ST_RUN) ? hb_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q  <= '0;
            sw_q         <= '0;
            for (int i = 0; i < SWITCH_W; i++) deb_cnt_q[i] <= '0;
            state_q      <= ST_IDLE;
            lcnt_q       <= '0;
            lost_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
            hb_q         <= '0;
        end else begin
            lock_sync_q  <= {lock_sync_q[0], pll_lock_i};
            sw_q         <= sw_d;
            for (int i = 0; i < SWITCH_W; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q      <= state_d;
            lcnt_q       <= lcnt_d;
            lost_q       <= lost_d;
            core_rst_n_q <= (state_d == ST_RUN);
            hb_q         <= hb_d;
        end
    end

    assign switch_o     = sw_q;
    assign core_rst_n_o = core_rst_n_q;
    assign lock_lost_o  = lost_q;
    assign heartbeat_o  = hb_q[HB_W-1];

endmodule

// File: tb/tb_emu_bus_bridge.sv
// Self-checking bench for emu_bus_bridge: a behavioural model (delay queues, streak
// counters, run-phase tracker) checked every cycle, plus directed literal checkpoints.
module tb_emu_bus_bridge;

    localparam int DATA_W      = 8;
    localparam int CTRL_IN_W   = 3;
    localparam int CTRL_OUT_W  = 2;
    localparam int SYNC_STAGES = 2;
    localparam int OUT_STAGES  = 2;
    localparam int SWITCH_W    = 2;
    localparam int DEB_CYCLES  = 8;
    localparam int LOCK_CYCLES = 4;
    localparam int HB_W        = 4;
    localparam int IN_W        = SWITCH_W + CTRL_IN_W + DATA_W;
    localparam int OUT_W       = CTRL_OUT_W + DATA_W;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  pll_lock_i = 1'b0;
    logic [SWITCH_W-1:0]   switch_i = '0;
    logic [DATA_W-1:0]     data_i = '0;
    logic [CTRL_IN_W-1:0]  data_ctrl_i = '0;
    logic [DATA_W-1:0]     hash_i = '0;
    logic [CTRL_OUT_W-1:0] hash_ctrl_i = '0;

    logic [DATA_W-1:0]     data_o, z_data_o;
    logic [CTRL_IN_W-1:0]  data_ctrl_o, z_data_ctrl_o;
    logic [DATA_W-1:0]     hash_o, z_hash_o;
    logic [CTRL_OUT_W-1:0] hash_ctrl_o, z_hash_ctrl_o;
    logic [SWITCH_W-1:0]   switch_o, z_switch_o;
    logic                  core_rst_n_o, z_core_rst_n_o;
    logic                  lock_lost_o, z_lock_lost_o;
    logic                  heartbeat_o, z_heartbeat_o;

    emu_bus_bridge #(
        .DATA_W(DATA_W), .CTRL_IN_W(CTRL_IN_W), .CTRL_OUT_W(CTRL_OUT_W),
        .SYNC_STAGES(SYNC_STAGES), .OUT_STAGES(OUT_STAGES), .SWITCH_W(SWITCH_W),
        .DEB_CYCLES(DEB_CYCLES), .LOCK_CYCLES(LOCK_CYCLES), .HB_W(HB_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .switch_i(switch_i),
        .data_i(data_i), .data_ctrl_i(data_ctrl_i), .data_o(data_o), .data_ctrl_o(data_ctrl_o),
        .hash_i(hash_i), .hash_ctrl_i(hash_ctrl_i), .hash_o(hash_o), .hash_ctrl_o(hash_ctrl_o),
        .switch_o(switch_o), .core_rst_n_o(core_rst_n_o), .lock_lost_o(lock_lost_o),
        .heartbeat_o(heartbeat_o)
    );

    // Same configuration with a combinational hash path.
    emu_bus_bridge #(
        .DATA_W(DATA_W), .CTRL_IN_W(CTRL_IN_W), .CTRL_OUT_W(CTRL_OUT_W),
        .SYNC_STAGES(SYNC_STAGES), .OUT_STAGES(0), .SWITCH_W(SWITCH_W),
        .DEB_CYCLES(DEB_CYCLES), .LOCK_CYCLES(LOCK_CYCLES), .HB_W(HB_W)
    ) dut_comb (
        .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .switch_i(switch_i),
        .data_i(data_i), .data_ctrl_i(data_ctrl_i), .data_o(z_data_o), .data_ctrl_o(z_data_ctrl_o),
        .hash_i(hash_i), .hash_ctrl_i(hash_ctrl_i), .hash_o(z_hash_o), .hash_ctrl_o(z_hash_ctrl_o),
        .switch_o(z_switch_o), .core_rst_n_o(z_core_rst_n_o), .lock_lost_o(z_lock_lost_o),
        .heartbeat_o(z_heartbeat_o)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_no <= 0;
        else        edge_no <= edge_no + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_WAIT, M_RUN} mphase_e;

    mphase_e             m_phase = M_IDLE;
    int                  m_streak = 0;
    int                  m_hb = 0;
    int                  m_deb [SWITCH_W] = '{default: 0};
    logic [SWITCH_W-1:0] m_sw_o = '0;
    logic                m_lost = 1'b0;
    logic [IN_W-1:0]     pin_q [$];
    logic [OUT_W-1:0]    hash_q [$];
    logic                lock_q [$];

    logic                lock_prev, was_run;
    logic [SWITCH_W-1:0] swo_prev, sws_prev;
    logic [IN_W-1:0]     in_prev;

    function automatic logic [IN_W-1:0] exp_in();
        return (pin_q.size() == SYNC_STAGES) ? pin_q[0] : '0;
    endfunction

    function automatic logic [OUT_W-1:0] exp_hash();
        return (hash_q.size() == OUT_STAGES) ? hash_q[0] : '0;
    endfunction

    function automatic logic exp_lock();
        return (lock_q.size() == 2) ? lock_q[0] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = M_IDLE;
            m_streak = 0;
            m_hb     = 0;
            m_sw_o   = '0;
            m_lost   = 1'b0;
            for (int i = 0; i < SWITCH_W; i++) m_deb[i] = 0;
            pin_q.delete();
            hash_q.delete();
            lock_q.delete();
        end else begin
            lock_prev = exp_lock();
            in_prev   = exp_in();
            sws_prev  = in_prev[IN_W-1 -: SWITCH_W];
            swo_prev  = m_sw_o;
            was_run   = (m_phase == M_RUN);

            case (m_phase)
                M_IDLE: m_phase = M_WAIT;
                M_WAIT: begin
                    if (lock_prev && !swo_prev[0]) begin
                        m_streak++;
                        if (m_streak == LOCK_CYCLES) begin
                            m_phase  = M_RUN;
                            m_streak = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
                M_RUN: begin
                    if (!lock_prev) begin
                        m_lost  = 1'b1;
                        m_phase = M_WAIT;
                    end else if (swo_prev[0]) begin
                        m_phase = M_WAIT;
                    end
                end
                default: m_phase = M_IDLE;
            endcase

            m_hb = was_run ? (m_hb + 1) % (1 << HB_W) : 0;

            for (int i = 0; i < SWITCH_W; i++) begin
                if (sws_prev[i] != m_sw_o[i]) begin
                    m_deb[i]++;
                    if (m_deb[i] == DEB_CYCLES) begin
                        m_sw_o[i] = ~m_sw_o[i];
                        m_deb[i]  = 0;
                    end
                end else begin
                    m_deb[i] = 0;
                end
            end

            pin_q.push_back({switch_i, data_ctrl_i, data_i});
            if (pin_q.size() > SYNC_STAGES) void'(pin_q.pop_front());
            hash_q.push_back({hash_ctrl_i, hash_i});
            if (hash_q.size() > OUT_STAGES) void'(hash_q.pop_front());
            lock_q.push_back(pll_lock_i);
            if (lock_q.size() > 2) void'(lock_q.pop_front());
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [IN_W-1:0]  cur_in;
    logic [OUT_W-1:0] cur_hash;

    always @(negedge clk) begin
        cur_in   = exp_in();
        cur_hash = exp_hash();
        check("data_o",         data_o,         cur_in[DATA_W-1:0]);
        check("data_ctrl_o",    data_ctrl_o,    cur_in[DATA_W +: CTRL_IN_W]);
        check("hash_o",         hash_o,         cur_hash[DATA_W-1:0]);
        check("hash_ctrl_o",    hash_ctrl_o,    cur_hash[DATA_W +: CTRL_OUT_W]);
        check("switch_o",       switch_o,       m_sw_o);
        check("core_rst_n_o",   core_rst_n_o,   m_phase == M_RUN);
        check("lock_lost_o",    lock_lost_o,    m_lost);
        check("heartbeat_o",    heartbeat_o,    (m_hb >> (HB_W - 1)) & 1);
        check("comb.hash_o",    z_hash_o,       hash_i);
        check("comb.hash_ctrl", z_hash_ctrl_o,  hash_ctrl_i);
        check("comb.data_o",    z_data_o,       cur_in[DATA_W-1:0]);
        check("comb.data_ctrl", z_data_ctrl_o,  cur_in[DATA_W +: CTRL_IN_W]);
        check("comb.switch_o",  z_switch_o,     m_sw_o);
        check("comb.core_rst",  z_core_rst_n_o, m_phase == M_RUN);
        check("comb.lock_lost", z_lock_lost_o,  m_lost);
        check("comb.heartbeat", z_heartbeat_o,  (m_hb >> (HB_W - 1)) & 1);
    end

    // ---------------- directed stimulus ----------------
    // Returns 2 time units after posedge number n (edges counted since rst_n release).
    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_no < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_edge timeout: at edge %0d, required edge %0d", edge_no, n);
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".data_o"},    data_o,       '0);
        check({tag, ".hash_o"},    hash_o,       '0);
        check({tag, ".switch_o"},  switch_o,     '0);
        check({tag, ".core_rst"},  core_rst_n_o, 1'b0);
        check({tag, ".lock_lost"}, lock_lost_o,  1'b0);
        check({tag, ".heartbeat"}, heartbeat_o,  1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Data sync and hash retime latency.
        wait_edge(2);
        data_i      = 8'hA5;
        data_ctrl_i = 3'd5;
        hash_i      = 8'h3C;
        hash_ctrl_i = 2'd2;
        #1;
        check("lit.comb_hash_same_cycle", z_hash_o, 8'h3C);
        wait_edge(3);
        check("lit.data_o_edge3", data_o, 8'h00);
        check("lit.hash_o_edge3", hash_o, 8'h00);
        wait_edge(4);
        check("lit.data_o_edge4", data_o, 8'hA5);
        check("lit.hash_o_edge4", hash_o, 8'h3C);

        // Lock qualification and heartbeat.
        wait_edge(9);
        pll_lock_i = 1'b1;
        data_i     = 8'h5A;
        wait_edge(14);
        check("lit.core_rst_edge14", core_rst_n_o, 1'b0);
        wait_edge(15);
        check("lit.core_rst_edge15", core_rst_n_o, 1'b1);
        wait_edge(22);
        check("lit.heartbeat_edge22", heartbeat_o, 1'b0);
        wait_edge(23);
        check("lit.heartbeat_edge23", heartbeat_o, 1'b1);

        // Short switch pulse is rejected, a long one accepted.
        wait_edge(25);
        switch_i = 2'b10;
        wait_edge(30);
        switch_i = 2'b00;
        wait_edge(33);
        check("lit.switch_short_pulse", switch_o, 2'b00);
        switch_i = 2'b10;
        wait_edge(42);
        check("lit.switch_edge42", switch_o, 2'b00);
        wait_edge(43);
        check("lit.switch_edge43", switch_o, 2'b10);

        // User hold-off via switch_o[0] while running.
        wait_edge(45);
        switch_i = 2'b11;
        wait_edge(55);
        check("lit.holdoff_core_edge55", core_rst_n_o, 1'b1);
        wait_edge(56);
        check("lit.holdoff_core_edge56", core_rst_n_o, 1'b0);
        check("lit.holdoff_lost", lock_lost_o, 1'b0);
        wait_edge(58);
        switch_i = 2'b10;
        wait_edge(71);
        check("lit.holdoff_release_edge71", core_rst_n_o, 1'b0);
        wait_edge(72);
        check("lit.holdoff_release_edge72", core_rst_n_o, 1'b1);

        // Lock loss in RUN, then relock.
        wait_edge(79);
        pll_lock_i = 1'b0;
        wait_edge(81);
        check("lit.lockloss_core_edge81", core_rst_n_o, 1'b1);
        check("lit.lockloss_lost_edge81", lock_lost_o, 1'b0);
        wait_edge(82);
        check("lit.lockloss_core_edge82", core_rst_n_o, 1'b0);
        check("lit.lockloss_lost_edge82", lock_lost_o, 1'b1);
        wait_edge(84);
        pll_lock_i = 1'b1;
        wait_edge(89);
        check("lit.relock_edge89", core_rst_n_o, 1'b0);
        wait_edge(90);
        check("lit.relock_edge90", core_rst_n_o, 1'b1);
        check("lit.relock_lost_sticky", lock_lost_o, 1'b1);

        // Async reset mid-qualification restarts the count.
        wait_edge(94);
        pll_lock_i = 1'b0;
        wait_edge(99);
        pll_lock_i = 1'b1;
        wait_edge(103);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_edge(5);
        check("lit.after_reset_edge5", core_rst_n_o, 1'b0);
        wait_edge(6);
        check("lit.after_reset_edge6", core_rst_n_o, 1'b1);
        check("lit.after_reset_lost", lock_lost_o, 1'b0);
        wait_edge(9);
        check("lit.after_reset_sw_edge9", switch_o, 2'b00);
        wait_edge(10);
        check("lit.after_reset_sw_edge10", switch_o, 2'b10);
        wait_edge(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
